btn_mode_debounce_counter: RTL
==============================

// Module: btn_mode_debounce_counter
// PURPOSE
//  Debounces one raw push-button and counts accepted presses into a 3-bit mode index.
//  Sits upstream of the OE decoder: q drives sel_3b, which chooses the active count rate.
//  Sampling uses the shared ena1khz strobe from the clock-enable divider, so no local
//  prescaler is needed.
// PARAMETERS
//  DB_CNT    20    consecutive identical ena1khz samples needed to accept a level change (>=2)
//  MODE_MAX  5     last mode value; q wraps MODE_MAX -> 0 (1..7)
//  LONG_CNT  1000  ena1khz samples of continuous hold for a long press (used only with LONG_PRESS_EN)
// PORTS
//  ckht        in   1  system clock, all flops on rising edge
//  rst_n       in   1  asynchronous reset, active-low
//  ena1khz     in   1  1-cycle sample strobe, 1 kHz
//  btn         in   1  raw button, active-high, asynchronous to ckht, may bounce
//  q           out  3  mode index 0..MODE_MAX, feeds OE decoder sel_3b
//  press_pulse out  1  1-cycle strobe per accepted press
//  long_pulse  out  1  1-cycle strobe per long press (tied 0 without LONG_PRESS_EN)
//  btn_level   out  1  debounced button level
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): q=0, press_pulse=0, long_pulse=0, btn_level=0.
//    Synchronizer flops=0, debounce count=0, FSM=UP. Release is synchronous to ckht.
//  - btn goes through a 2-flop synchronizer clocked every ckht cycle. Its output is btn_s.
//  - The FSM advances only on cycles with ena1khz=1. Otherwise all state holds.
//  - FSM states:
//    - UP: stable released, btn_level=0. If btn_s=1 -> UP_CHK with cnt=1.
//    - UP_CHK: if btn_s=0 -> UP with cnt=0.
//      Else if cnt==DB_CNT-1 -> DN (accept press). Else cnt++.
//    - DN: stable pressed, btn_level=1. If btn_s=0 -> DN_CHK with cnt=1.
//    - DN_CHK: if btn_s=1 -> DN with cnt=0.
//      Else if cnt==DB_CNT-1 -> UP (accept release). Else cnt++.
//  - Accept press happens at the ckht edge that samples the DB_CNT-th consecutive 1.
//    At that edge:
//    - press_pulse<=1 for exactly one ckht cycle.
//    - q<=(q==MODE_MAX)?0:q+1.
//    - btn_level<=1.
//  - Release produces no pulse and leaves q unchanged. Only press events change q.
//  - Bounce shorter than DB_CNT samples is ignored in both directions.
//  - Timing: min latency is 2 ckht (synchronizer) + DB_CNT ena1khz periods. Max adds one period.
//  - q is never outside 0..MODE_MAX.
//  - rst_n low mid-debounce or mid-hold aborts the event. No pulse is emitted.
//  - After reset, a button already held is accepted as a new press once DB_CNT samples of 1 are seen.
//  - cnt is wide enough for max(DB_CNT, LONG_CNT) and never wraps.
// CONFIGURATION
//  LONG_PRESS_EN defined:
//    - In DN, a hold counter lc increments per ena1khz. lc is cleared on entry to DN.
//    - lc is not cleared on a DN->DN_CHK->DN glitch return.
//    - When lc reaches LONG_CNT-1 on a strobe: q<=0 and long_pulse<=1 for one ckht cycle.
//    - lc then saturates: at most one long press per hold. The later release is normal.
//    - If the press edge and long edge could coincide (LONG_CNT<=1), long wins: q=0.
//  LONG_PRESS_EN undefined:
//    - No hold counter is built and long_pulse is tied 0.
//    - Holding the button never changes q beyond the single press increment.
// TESTING
//  Bench params: DB_CNT=4, MODE_MAX=5, LONG_CNT=10. ena1khz is 1 cycle in every 4 ckht.
//  T1 reset: hold rst_n=0 with btn=1 -> q=0, pulses 0, btn_level=0.
//     Release reset with btn=1 -> q=1 after 4 strobes.
//  T2 clean press: btn high 10 strobes, then low 10 -> press_pulse exactly 1 cycle, q 0->1.
//     btn_level rises on 4th sample and falls on 4th low sample.
//  T3 bounce: toggle btn every strobe for 3 highs between lows, then stable low
//     -> no press_pulse, q unchanged.
//  T4 wrap: 6 clean presses from q=0 -> q sequence 1,2,3,4,5,0.
//     Exactly 6 press_pulse cycles total.
//  T5 mid-debounce reset: btn high for 3 strobes, rst_n pulse low, btn stays high
//     -> no pulse before reset; q=0 after reset.
//     q=1 four strobes after rst_n release.
//  T6 long press (LONG_PRESS_EN): from q=3, hold btn 25 strobes
//     -> press_pulse: q=4; 10 strobes later long_pulse: q=0; no further pulses.
//     Without macro -> q=4, long_pulse never 1.

Source files
------------

// File: rtl/btn_mode_debounce_counter.sv
// rtl/btn_mode_debounce_counter.sv - debounced push-button mode counter (q cycles 0..MODE_MAX)
// Optional long-press reset of q to 0 is built when LONG_PRESS_EN is defined.
module btn_mode_debounce_counter #(
  parameter int DB_CNT   = 20,
  parameter int MODE_MAX = 5,
  parameter int LONG_CNT = 1000
) (
  input  logic       ckht,
  input  logic       rst_n,
  input  logic       ena1khz,
  input  logic       btn,
  output logic [2:0] q,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       btn_level
);

  localparam int CNT_MAX = (DB_CNT > LONG_CNT) ? DB_CNT : LONG_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {UP, UP_CHK, DN, DN_CHK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          btn_s;
  logic          press_acc;
  logic          long_fire;
  logic [2:0]    mode_q, mode_d;
  logic          press_q, press_d;
  logic          long_q, long_d;
  logic          level_q, level_d;

  // btn is asynchronous to ckht, so it is resynchronised every cycle, not only on strobes
  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UP;
      cnt_q   <= '0;
      mode_q  <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      press_q <= press_d;
      long_q  <= long_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_acc = 1'b0;
    if (ena1khz) begin
      case (state_q)
        UP: begin
          if (btn_s) begin
            state_d = UP_CHK;
            cnt_d   = CW'(1);
          end
        end
        UP_CHK: begin
          if (!btn_s) begin
            state_d = UP;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DB_CNT - 1)) begin
            state_d   = DN;
            cnt_d     = '0;
            press_acc = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DN: begin
          if (!btn_s) begin
            state_d = DN_CHK;
            cnt_d   = CW'(1);
          end
        end
        DN_CHK: begin
          if (btn_s) begin
            state_d = DN;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DB_CNT - 1)) begin
            state_d = UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = UP;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CNT + 1);

  logic [LW-1:0] lc_q, lc_d;

  // lc parks at LONG_CNT after firing so a single hold yields at most one long press
  always_comb begin
    lc_d      = lc_q;
    long_fire = 1'b0;
    if (ena1khz) begin
      if (press_acc) begin
        if (LONG_CNT <= 1) begin
          long_fire = 1'b1;
          lc_d      = LW'(LONG_CNT);
        end else begin
          lc_d = '0;
        end
      end else if (state_q == DN && lc_q < LW'(LONG_CNT)) begin
        if (lc_q == LW'(LONG_CNT - 1)) long_fire = 1'b1;
        lc_d = lc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) lc_q <= '0;
    else        lc_q <= lc_d;
  end
`else
  assign long_fire = 1'b0;
`endif

  always_comb begin
    mode_d  = mode_q;
    press_d = press_acc;
    long_d  = long_fire;
    level_d = (state_d == DN) || (state_d == DN_CHK);
    if (long_fire)
      mode_d = '0;
    else if (press_acc)
      mode_d = (mode_q == 3'(MODE_MAX)) ? 3'd0 : mode_q + 3'd1;
  end

  assign q           = mode_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign btn_level   = level_q;

endmodule
